// File: rtl/lfsr_prng_gen_if.sv
// ============================================================================
// Module      : lfsr_prng_gen_if
// Description : Control/data bundle between an LFSR noise consumer (master)
//               and the lfsr_prng_gen source (slave).
//   enable     master->slave  advance the LFSR one step
//   load       master->slave  load seed_in into the state
//   seed_in    master->slave  run-time seed (WIDTH bits)
//   inject_en  master->slave  fold parity of data into the feedback bit
//   data       master->slave  injection data (DATA_W bits)
//   out        slave->master  signed noise word (OUT_W bits)
//   valid      slave->master  warm-up complete
//   lockup     slave->master  sticky all-zero recovery flag
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lfsr_prng_gen_if #(
  parameter int WIDTH  = 32,
  parameter int OUT_W  = 16,
  parameter int DATA_W = 2
);
  logic                     enable;
  logic                     load;
  logic [WIDTH-1:0]         seed_in;
  logic                     inject_en;
  logic [DATA_W-1:0]        data;
  logic signed [OUT_W-1:0]  out;
  logic                     valid;
  logic                     lockup;

  modport master (
    output enable, load, seed_in, inject_en, data,
    input  out, valid, lockup
  );

  modport slave (
    input  enable, load, seed_in, inject_en, data,
    output out, valid, lockup
  );
endinterface

`default_nettype wire

// File: rtl/lfsr_prng_gen.sv
// ============================================================================
// Module      : lfsr_prng_gen
// Description : Parametrised Fibonacci LFSR pseudo-random source with run-time
//               seed load, optional data injection into the feedback bit,
//               all-zero lockup recovery and a warm-up qualifier.
//   clk    in  clock, rising edge
//   reset  in  synchronous active-high reset
//   bus    slave modport of lfsr_prng_gen_if (enable, load, seed_in,
//          inject_en, data in; out, valid, lockup out)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_prng_gen #(
  parameter int               WIDTH  = 32,
  parameter int               OUT_W  = 16,
  parameter logic [WIDTH-1:0] TAPS   = 32'h80200003,
  parameter logic [WIDTH-1:0] SEED   = 32'h00000001,
  parameter int               DATA_W = 2
) (
  input  wire logic          clk,
  input  wire logic          reset,
  lfsr_prng_gen_if.slave     bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

  logic [WIDTH-1:0] state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             lockup_q, lockup_d;
  logic             fb;

  // Feedback is the tap parity, optionally perturbed by the parity of data.
  assign fb = (^(state_q & TAPS)) ^ (bus.inject_en & (^bus.data));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lockup_d = lockup_q;
    if (bus.load) begin
      state_d  = bus.seed_in;
      cnt_d    = '0;
      lockup_d = 1'b0;
    end else if (bus.enable && (state_q == '0)) begin
      // An all-zero state can never leave zero on its own (without injection
      // it is a fixed point), so recover unconditionally rather than shift.
      state_d  = SEED;
      cnt_d    = '0;
      lockup_d = 1'b1;
    end else if (bus.enable) begin
      state_d = {state_q[WIDTH-2:0], fb};
      if (cnt_q != CNT_FULL) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= SEED;
      cnt_q    <= '0;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lockup_q <= lockup_d;
    end
  end

  assign bus.out    = $signed(state_q[WIDTH-1 -: OUT_W]);
  assign bus.valid  = (cnt_q == CNT_FULL);
  assign bus.lockup = lockup_q;

endmodule

`default_nettype wire

// File: tb/tb_lfsr_prng_gen.sv
// ============================================================================
// Module      : tb_lfsr_prng_gen
// Description : Self-checking bench for lfsr_prng_gen against a behavioural
//               model of the LFSR rules (directed scenarios plus random run).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lfsr_prng_gen;

  localparam int          WIDTH  = 32;
  localparam int          OUT_W  = 16;
  localparam int          DATA_W = 2;
  localparam logic [31:0] TAPS   = 32'h80200003;
  localparam logic [31:0] SEED   = 32'h00000001;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  lfsr_prng_gen_if #(.WIDTH(WIDTH), .OUT_W(OUT_W), .DATA_W(DATA_W)) if0 ();

  lfsr_prng_gen #(
    .WIDTH(WIDTH), .OUT_W(OUT_W), .TAPS(TAPS), .SEED(SEED), .DATA_W(DATA_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (if0)
  );

  always #5 clk = ~clk;

  // Behavioural model: state as a number, warm-up as a plain step count.
  logic [31:0] m_state;
  int          m_steps;
  bit          m_lock;

  function automatic bit m_valid();
    return m_steps >= WIDTH;
  endfunction

  function automatic logic [5:0] m_cnt();
    return (m_steps >= WIDTH) ? 6'(WIDTH) : 6'(m_steps);
  endfunction

  task automatic model_update();
    int ones;
    if (reset) begin
      m_state = SEED; m_steps = 0; m_lock = 0;
    end else if (if0.load) begin
      m_state = if0.seed_in; m_steps = 0; m_lock = 0;
    end else if (if0.enable) begin
      if (m_state == 0) begin
        m_state = SEED; m_steps = 0; m_lock = 1;
      end else begin
        ones = $countones(m_state & TAPS);
        if (if0.inject_en) ones += $countones(if0.data);
        m_state = (m_state << 1) | 32'(ones % 2);
        if (m_steps < WIDTH) m_steps++;
      end
    end
  endtask

  task automatic cycle();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if0.enable = 0; if0.load = 0; if0.seed_in = '0;
    if0.inject_en = 0; if0.data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    cycle();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (dut.state_q !== 32'h00000001) begin errors++; $display("FAIL reset_state got=%h exp=%h", dut.state_q, 32'h1); end
    checks++; if (if0.out !== 16'sh0000) begin errors++; $display("FAIL reset_out got=%h exp=0000", if0.out); end
    checks++; if (if0.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", if0.valid); end
    checks++; if (if0.lockup !== 1'b0) begin errors++; $display("FAIL reset_lockup got=%b exp=0", if0.lockup); end
    checks++; if (dut.cnt_q !== 6'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", dut.cnt_q); end
  endtask

  task automatic test_three_steps();
    logic [31:0] exp_seq [3] = '{32'h3, 32'h6, 32'hD};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      if0.enable = 1;
      cycle();
      checks++; if (dut.state_q !== exp_seq[i]) begin errors++; $display("FAIL step%0d_state got=%h exp=%h", i, dut.state_q, exp_seq[i]); end
      checks++; if (if0.out !== 16'sh0000) begin errors++; $display("FAIL step%0d_out got=%h exp=0000", i, if0.out); end
    end
    idle_inputs();
  endtask

  task automatic test_warmup();
    logic [31:0] held;
    do_reset();
    for (int s = 1; s <= 40; s++) begin
      if0.enable = 1;
      cycle();
      checks++; if (if0.valid !== (s >= 32)) begin errors++; $display("FAIL warmup_valid step=%0d got=%b exp=%b", s, if0.valid, (s >= 32)); end
      checks++; if (dut.state_q !== m_state) begin errors++; $display("FAIL warmup_state step=%0d got=%h exp=%h", s, dut.state_q, m_state); end
    end
    held = m_state;
    if0.enable = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++; if (dut.state_q !== held) begin errors++; $display("FAIL hold_state got=%h exp=%h", dut.state_q, held); end
      checks++; if (if0.valid !== 1'b1) begin errors++; $display("FAIL hold_valid got=%b exp=1", if0.valid); end
    end
  endtask

  task automatic test_lockup();
    do_reset();
    if0.load = 1; if0.seed_in = 32'h0;
    cycle();
    if0.load = 0;
    checks++; if (dut.state_q !== 32'h0) begin errors++; $display("FAIL zero_load_state got=%h exp=0", dut.state_q); end
    if0.enable = 1;
    cycle();
    checks++; if (dut.state_q !== 32'h1) begin errors++; $display("FAIL recover_state got=%h exp=1", dut.state_q); end
    checks++; if (if0.lockup !== 1'b1) begin errors++; $display("FAIL recover_lockup got=%b exp=1", if0.lockup); end
    checks++; if (if0.valid !== 1'b0) begin errors++; $display("FAIL recover_valid got=%b exp=0", if0.valid); end
    for (int i = 0; i < 8; i++) begin
      if0.enable = 1'($urandom_range(0, 1));
      cycle();
      checks++; if (if0.lockup !== 1'b1) begin errors++; $display("FAIL lockup_sticky got=%b exp=1", if0.lockup); end
    end
    if0.enable = 0; if0.load = 1; if0.seed_in = 32'h12345678;
    cycle();
    idle_inputs();
    checks++; if (if0.lockup !== 1'b0) begin errors++; $display("FAIL lockup_clear got=%b exp=0", if0.lockup); end
  endtask

  task automatic test_load_priority();
    do_reset();
    if0.load = 1; if0.enable = 1; if0.seed_in = 32'hDEADBEEF;
    cycle();
    idle_inputs();
    checks++; if (dut.state_q !== 32'hDEADBEEF) begin errors++; $display("FAIL load_state got=%h exp=DEADBEEF", dut.state_q); end
    checks++; if (if0.out !== -16'sd8531) begin errors++; $display("FAIL load_out got=%0d exp=-8531", if0.out); end
    checks++; if (if0.valid !== 1'b0) begin errors++; $display("FAIL load_valid got=%b exp=0", if0.valid); end
    checks++; if (dut.cnt_q !== 6'd0) begin errors++; $display("FAIL load_cnt got=%0d exp=0", dut.cnt_q); end
  endtask

  task automatic test_inject();
    do_reset();
    if0.enable = 1; if0.inject_en = 1; if0.data = 2'b01;
    cycle();
    idle_inputs();
    checks++; if (dut.state_q !== 32'h2) begin errors++; $display("FAIL inject_state got=%h exp=2", dut.state_q); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    if0.enable = 1;
    repeat (10) cycle();
    checks++; if (dut.cnt_q !== 6'd10) begin errors++; $display("FAIL mid_cnt got=%0d exp=10", dut.cnt_q); end
    reset = 1;
    cycle();
    reset = 0;
    idle_inputs();
    checks++; if (dut.state_q !== SEED) begin errors++; $display("FAIL mid_reset_state got=%h exp=%h", dut.state_q, SEED); end
    checks++; if (if0.valid !== 1'b0 || if0.lockup !== 1'b0) begin errors++; $display("FAIL mid_reset_flags got=%b%b exp=00", if0.valid, if0.lockup); end
    checks++; if (dut.cnt_q !== 6'd0) begin errors++; $display("FAIL mid_reset_cnt got=%0d exp=0", dut.cnt_q); end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      reset         = (r < 2);
      if0.load      = (r >= 2 && r < 7);
      if0.seed_in   = ($urandom_range(0, 2) == 0) ? 32'h0 : 32'($urandom);
      if0.enable    = ($urandom_range(0, 3) != 0);
      if0.inject_en = 1'($urandom_range(0, 1));
      if0.data      = 2'($urandom_range(0, 3));
      cycle();
      checks++; if (dut.state_q !== m_state) begin errors++; $display("FAIL rnd_state i=%0d got=%h exp=%h", i, dut.state_q, m_state); end
      checks++; if (if0.out !== $signed(m_state[31:16])) begin errors++; $display("FAIL rnd_out i=%0d got=%h exp=%h", i, if0.out, m_state[31:16]); end
      checks++; if (if0.valid !== m_valid()) begin errors++; $display("FAIL rnd_valid i=%0d got=%b exp=%b", i, if0.valid, m_valid()); end
      checks++; if (if0.lockup !== m_lock) begin errors++; $display("FAIL rnd_lockup i=%0d got=%b exp=%b", i, if0.lockup, m_lock); end
      checks++; if (dut.cnt_q !== m_cnt()) begin errors++; $display("FAIL rnd_cnt i=%0d got=%0d exp=%0d", i, dut.cnt_q, m_cnt()); end
    end
    reset = 0;
    idle_inputs();
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    m_state = SEED; m_steps = 0; m_lock = 0;
    test_reset();
    test_three_steps();
    test_warmup();
    test_lockup();
    test_load_priority();
    test_inject();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
